// File: rtl/aes_redundant_pkg.sv
// Shared types and AES-128 arithmetic for the redundant encryptor.
package aes_redundant_pkg;

  localparam int unsigned AES_W = 128;

  typedef enum logic [1:0] {StIdle, StKeyld, StRun, StVote} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the state is bits [127-8i -: 8]; bytes are column-major (i = col*4 + row).
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) sr[c*4+w] = sb[((c + w) % 4)*4 + w];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[c*4];
      a1 = sr[c*4+1];
      a2 = sr[c*4+2];
      a3 = sr[c*4+3];
      if (last) begin
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return r ^ rk;
  endfunction

endpackage

// File: rtl/AES_Comp_ENC.sv
// Iterative AES-128 encryption lane: one round per enabled cycle, round keys derived on the fly.
module AES_Comp_ENC (
  input  logic [127:0] Kin,
  input  logic [127:0] Din,
  output logic [127:0] Dout,
  input  logic         Krdy,
  input  logic         Drdy,
  output logic         Kvld,
  output logic         Dvld,
  input  logic         EN,
  input  logic         CLK,
  input  logic         RSTn
);
  import aes_redundant_pkg::*;

  logic [127:0] key_q, rk_q, state_q, dout_q;
  logic [7:0]   rcon_q;
  logic [3:0]   rnd_q;
  logic         busy_q, kpend_q, kvld_q, dvld_q;
  logic [127:0] rk_next, round_out;

  // Round datapath; round 10 skips MixColumns.
  always_comb begin
    rk_next   = next_key(rk_q, rcon_q);
    round_out = aes_round(state_q, rk_next, rnd_q == 4'd10);
  end

  // Key capture, round sequencing and one-cycle Kvld/Dvld pulses.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      key_q   <= '0;
      rk_q    <= '0;
      state_q <= '0;
      dout_q  <= '0;
      rcon_q  <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      kpend_q <= 1'b0;
      kvld_q  <= 1'b0;
      dvld_q  <= 1'b0;
    end else if (EN) begin
      kvld_q  <= kpend_q;
      kpend_q <= 1'b0;
      dvld_q  <= 1'b0;
      if (busy_q) begin
        state_q <= round_out;
        rk_q    <= rk_next;
        rcon_q  <= xtime(rcon_q);
        rnd_q   <= rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          busy_q <= 1'b0;
          dout_q <= round_out;
          dvld_q <= 1'b1;
        end
      end else if (Krdy) begin
        key_q   <= Kin;
        kpend_q <= 1'b1;
      end else if (Drdy) begin
        state_q <= Din ^ key_q;
        rk_q    <= key_q;
        rcon_q  <= 8'h01;
        rnd_q   <= 4'd1;
        busy_q  <= 1'b1;
      end
    end
  end

  assign Dout = dout_q;
  assign Kvld = kvld_q;
  assign Dvld = dvld_q;

endmodule

// File: rtl/aes_bit_voter.sv
// Combinational bitwise majority over the masked lanes, with per-lane mismatch and tie flags.
module aes_bit_voter #(
  parameter int unsigned NCOPY = 3,
  parameter int unsigned W     = 128
) (
  input  logic [NCOPY-1:0][W-1:0] lanes_i,
  input  logic [NCOPY-1:0]        mask_i,
  output logic [W-1:0]            vote_o,
  output logic [NCOPY-1:0]        mismatch_o,
  output logic                    tie_o
);

  localparam int unsigned CntW = $clog2(NCOPY + 1) + 1;

  logic [CntW-1:0] n_act;
  logic [CntW-1:0] cnt;

  // Per bit: 1 wins only with a strict majority; an exact half is a tie and resolves to 0.
  always_comb begin
    n_act      = '0;
    cnt        = '0;
    vote_o     = '0;
    tie_o      = 1'b0;
    mismatch_o = '0;
    for (int i = 0; i < NCOPY; i++) n_act = n_act + CntW'(mask_i[i]);
    for (int b = 0; b < W; b++) begin
      cnt = '0;
      for (int i = 0; i < NCOPY; i++) begin
        if (mask_i[i]) cnt = cnt + CntW'(lanes_i[i][b]);
      end
      vote_o[b] = ({cnt, 1'b0} > {1'b0, n_act});
      if (n_act != '0 && {cnt, 1'b0} == {1'b0, n_act}) tie_o = 1'b1;
    end
    for (int i = 0; i < NCOPY; i++) begin
      mismatch_o[i] = mask_i[i] && (lanes_i[i] != vote_o);
    end
  end

endmodule

// File: rtl/aes_redundant_enc.sv
// N-lane redundant AES-128 encryptor: broadcasts requests, then votes or compares lane results.
module aes_redundant_enc
  import aes_redundant_pkg::*;
#(
  parameter int unsigned NCOPY   = 3,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned FCNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [AES_W-1:0]  Kin,
  input  logic [AES_W-1:0]  Din,
  input  logic              Krdy,
  input  logic              Drdy,
  input  logic              MODE,
  input  logic [NCOPY-1:0]  LANE_EN,
  input  logic              FCLR,
  output logic [AES_W-1:0]  Dout,
  output logic              Kvld,
  output logic              Dvld,
  output logic              BSY,
  output logic              FAULT,
  output logic [NCOPY-1:0]  FAULT_LANE,
  output logic [FCNT_W-1:0] FAULT_CNT
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(TIMEOUT - 1);

  state_e                       state_q;
  logic [NCOPY-1:0]             mask_q, done_q, tout_q;
  logic [TIMER_W-1:0]           timer_q;
  logic                         key_loaded_q, mode_q;
  logic [AES_W-1:0]             dout_q;
  logic                         kvld_q, dvld_q, bsy_q, fault_q;
  logic [NCOPY-1:0]             fault_lane_q;
  logic [FCNT_W-1:0]            fcnt_q;

  logic                         idle_acc, acc_key, acc_data;
  logic [NCOPY-1:0]             lane_en, lane_kvld, lane_dvld;
  logic [NCOPY-1:0][AES_W-1:0]  lane_dout, vote_in;
  logic [NCOPY-1:0]             done_now, act, mismatch, blame;
  logic                         all_done, tie, agree, found, faulty, rst_n;
  logic [AES_W-1:0]             vote, ref_val, res_dout;
  logic [FCNT_W-1:0]            fcnt_inc;

  // Request acceptance; lanes see the new mask on the accepting edge itself.
  always_comb begin
    idle_acc = EN && (state_q == StIdle) && (LANE_EN != '0);
    acc_key  = idle_acc && Krdy;
    acc_data = idle_acc && !Krdy && Drdy && key_loaded_q;
    lane_en  = {NCOPY{EN}} & ((acc_key || acc_data) ? LANE_EN : mask_q);
  end

  assign rst_n = ~RST;

  for (genvar g = 0; g < NCOPY; g++) begin : g_lane
    AES_Comp_ENC u_lane (
      .Kin  (Kin),
      .Din  (Din),
      .Dout (lane_dout[g]),
      .Krdy (acc_key),
      .Drdy (acc_data),
      .Kvld (lane_kvld[g]),
      .Dvld (lane_dvld[g]),
      .EN   (lane_en[g]),
      .CLK  (CLK),
      .RSTn (rst_n)
    );
  end

  // Completion tracking; lane pulses are accumulated so lanes need not finish together.
  always_comb begin
    done_now = done_q | (((state_q == StKeyld) ? lane_kvld : lane_dvld) & mask_q);
    all_done = (done_now & mask_q) == mask_q;
    vote_in  = '0;
    for (int i = 0; i < NCOPY; i++) vote_in[i] = tout_q[i] ? '0 : lane_dout[i];
  end

  aes_bit_voter #(
    .NCOPY (NCOPY),
    .W     (AES_W)
  ) u_voter (
    .lanes_i    (vote_in),
    .mask_i     (mask_q),
    .vote_o     (vote),
    .mismatch_o (mismatch),
    .tie_o      (tie)
  );

  // Result selection for the VOTE cycle in both modes.
  always_comb begin
    act     = mask_q & ~tout_q;
    ref_val = '0;
    found   = 1'b0;
    agree   = 1'b1;
    for (int i = 0; i < NCOPY; i++) begin
      if (act[i] && !found) begin
        ref_val = lane_dout[i];
        found   = 1'b1;
      end
    end
    for (int i = 0; i < NCOPY; i++) begin
      if (act[i] && (lane_dout[i] != ref_val)) agree = 1'b0;
    end
    if (!mode_q) begin
      res_dout = vote;
      blame    = tout_q | mismatch;
      faulty   = (blame != '0) || tie;
    end else begin
      res_dout = agree ? ref_val : '0;
      blame    = agree ? tout_q : mask_q;
      faulty   = (blame != '0);
    end
    fcnt_inc = (&fcnt_q) ? fcnt_q : fcnt_q + 1'b1;
  end

  // Control FSM with registered outputs; a fault update overrides a coincident FCLR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      done_q       <= '0;
      tout_q       <= '0;
      timer_q      <= '0;
      key_loaded_q <= 1'b0;
      mode_q       <= 1'b0;
      dout_q       <= '0;
      kvld_q       <= 1'b0;
      dvld_q       <= 1'b0;
      bsy_q        <= 1'b0;
      fault_q      <= 1'b0;
      fault_lane_q <= '0;
      fcnt_q       <= '0;
    end else begin
      kvld_q <= 1'b0;
      dvld_q <= 1'b0;
      if (EN) begin
        if (FCLR) begin
          fault_q <= 1'b0;
          fcnt_q  <= '0;
        end
        unique case (state_q)
          StIdle: begin
            if (acc_key) begin
              state_q <= StKeyld;
              bsy_q   <= 1'b1;
              mask_q  <= LANE_EN;
              done_q  <= '0;
            end else if (acc_data) begin
              state_q <= StRun;
              bsy_q   <= 1'b1;
              mask_q  <= LANE_EN;
              done_q  <= '0;
              timer_q <= '0;
              mode_q  <= MODE;
            end
          end
          StKeyld: begin
            done_q <= done_now;
            if (all_done) begin
              kvld_q       <= 1'b1;
              key_loaded_q <= 1'b1;
              state_q      <= StIdle;
              bsy_q        <= 1'b0;
            end
          end
          StRun: begin
            done_q  <= done_now;
            timer_q <= timer_q + 1'b1;
            if (all_done || (timer_q == TimerLast)) begin
              tout_q  <= mask_q & ~done_now;
              state_q <= StVote;
            end
          end
          StVote: begin
            dout_q       <= res_dout;
            dvld_q       <= 1'b1;
            fault_lane_q <= blame;
            if (faulty) begin
              fault_q <= 1'b1;
              fcnt_q  <= FCLR ? FCNT_W'(1) : fcnt_inc;
            end
            state_q <= StIdle;
            bsy_q   <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign Dout       = dout_q;
  assign Kvld       = kvld_q;
  assign Dvld       = dvld_q;
  assign BSY        = bsy_q;
  assign FAULT      = fault_q;
  assign FAULT_LANE = fault_lane_q;
  assign FAULT_CNT  = fcnt_q;

endmodule

// File: tb/tb_aes_redundant_enc.sv
// Directed bench for the redundant encryptor with an expected-result scoreboard.
module tb_aes_redundant_enc;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst, en, krdy, drdy, mode, fclr;
  logic [127:0] kin, din, dout;
  logic [2:0]   lane_en, fault_lane;
  logic         kvld, dvld, bsy, fault;
  logic [7:0]   fault_cnt;

  typedef struct {
    logic [127:0] dout;
    logic [2:0]   lane;
    logic         fault;
    logic [7:0]   cnt;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aes_redundant_enc #(
    .NCOPY   (3),
    .TIMEOUT (16),
    .FCNT_W  (8)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .EN         (en),
    .Kin        (kin),
    .Din        (din),
    .Krdy       (krdy),
    .Drdy       (drdy),
    .MODE       (mode),
    .LANE_EN    (lane_en),
    .FCLR       (fclr),
    .Dout       (dout),
    .Kvld       (kvld),
    .Dvld       (dvld),
    .BSY        (bsy),
    .FAULT      (fault),
    .FAULT_LANE (fault_lane),
    .FAULT_CNT  (fault_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Watches for any Dvld over n cycles.
  task automatic no_dvld(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (dvld) seen = 1'b1;
    end
    chk(tag, 128'(seen), 128'd0);
  endtask

  task automatic key_load(input string tag, input logic with_drdy);
    kin = KEY; lane_en = 3'b111; krdy = 1'b1; drdy = with_drdy;
    tick();
    krdy = 1'b0; drdy = 1'b0;
    chk({tag, ".bsy0"}, 128'(bsy), 128'd1);
    chk({tag, ".kvld0"}, 128'(kvld), 128'd0);
    tick();
    chk({tag, ".bsy1"}, 128'(bsy), 128'd1);
    tick();
    chk({tag, ".kvld2"}, 128'(kvld), 128'd1);
    chk({tag, ".bsy2"}, 128'(bsy), 128'd0);
    tick();
    chk({tag, ".kvld_pulse"}, 128'(kvld), 128'd0);
  endtask

  // Issues one encryption, optionally pausing EN for `pause` cycles mid-RUN.
  task automatic run_enc(input string tag, input logic m, input logic [2:0] le, input int pause,
                         input exp_t e);
    int   lat;
    exp_t got;
    sb.push_back(e);
    din = PT; mode = m; lane_en = le; drdy = 1'b1;
    tick();
    drdy = 1'b0;
    chk({tag, ".bsy"}, 128'(bsy), 128'd1);
    lat = 0;
    while (!dvld && lat < 40) begin
      if (pause > 0 && lat == 4) en = 1'b0;
      if (pause > 0 && lat == 4 + pause) en = 1'b1;
      tick();
      lat++;
    end
    en = 1'b1;
    got = sb.pop_front();
    chk({tag, ".latency"}, 128'(lat), 128'(got.lat));
    chk({tag, ".dout"}, dout, got.dout);
    chk({tag, ".fault_lane"}, 128'(fault_lane), 128'(got.lane));
    chk({tag, ".fault"}, 128'(fault), 128'(got.fault));
    chk({tag, ".fault_cnt"}, 128'(fault_cnt), 128'(got.cnt));
    tick();
    chk({tag, ".dvld_pulse"}, 128'(dvld), 128'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; krdy = 1'b0; drdy = 1'b0; mode = 1'b0; fclr = 1'b0;
    kin = '0; din = '0; lane_en = 3'b111;
    tick();
    tick();
    rst = 1'b0;
    chk("reset.dout", dout, 128'd0);
    chk("reset.kvld", 128'(kvld), 128'd0);
    chk("reset.dvld", 128'(dvld), 128'd0);
    chk("reset.bsy", 128'(bsy), 128'd0);
    chk("reset.fault", 128'(fault), 128'd0);
    chk("reset.fault_lane", 128'(fault_lane), 128'd0);
    chk("reset.fault_cnt", 128'(fault_cnt), 128'd0);

    // Encrypt before any key load is ignored.
    din = PT; drdy = 1'b1;
    tick();
    drdy = 1'b0;
    chk("nokey.bsy", 128'(bsy), 128'd0);
    no_dvld("nokey.no_dvld", 14);

    key_load("keyld", 1'b0);
    // Simultaneous Krdy/Drdy: key load only, no encryption follows.
    key_load("krdy_drdy", 1'b1);
    no_dvld("krdy_drdy.no_dvld", 14);

    run_enc("nominal", 1'b0, 3'b111, 0, '{CT, 3'b000, 1'b0, 8'd0, 12});

    force dut.lane_dout = {CT, CT ^ 128'h1, CT};
    run_enc("vote_fault", 1'b0, 3'b111, 0, '{CT, 3'b010, 1'b1, 8'd1, 12});
    run_enc("cmp_fault", 1'b1, 3'b111, 0, '{128'd0, 3'b111, 1'b1, 8'd2, 12});
    release dut.lane_dout;

    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    chk("fclr.fault", 128'(fault), 128'd0);
    chk("fclr.fault_cnt", 128'(fault_cnt), 128'd0);

    // Two active lanes disagreeing on bits 1:0 -> both bits tie to 0, both lanes blamed.
    force dut.lane_dout = {CT, CT, CT ^ 128'h3};
    run_enc("tie", 1'b0, 3'b011, 0, '{CT & ~128'h3, 3'b011, 1'b1, 8'd1, 12});
    release dut.lane_dout;

    lane_en = 3'b000; drdy = 1'b1;
    tick();
    drdy = 1'b0;
    chk("mask0.bsy0", 128'(bsy), 128'd0);
    tick();
    chk("mask0.bsy1", 128'(bsy), 128'd0);

    // Lane 2 never reports done: timeout after TIMEOUT cycles, lane 2 votes 0 and is blamed.
    force dut.lane_dvld = 3'b011;
    run_enc("timeout", 1'b0, 3'b111, 0, '{CT, 3'b100, 1'b1, 8'd2, 17});
    release dut.lane_dvld;

    run_enc("en_pause", 1'b0, 3'b111, 3, '{CT, 3'b000, 1'b1, 8'd2, 15});

    // Reset during round 4 aborts the block.
    din = PT; mode = 1'b0; lane_en = 3'b111; drdy = 1'b1;
    tick();
    drdy = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.dout", dout, 128'd0);
    chk("midrst.bsy", 128'(bsy), 128'd0);
    chk("midrst.fault", 128'(fault), 128'd0);
    chk("midrst.fault_cnt", 128'(fault_cnt), 128'd0);
    no_dvld("midrst.no_dvld", 15);
    // Key was cleared by reset, so a new request is ignored.
    drdy = 1'b1;
    tick();
    drdy = 1'b0;
    chk("midrst.nokey_bsy", 128'(bsy), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
